mdu_hilo: RTL and testbench

- Iterative multiply/divide unit owning the HI/LO architectural registers.
- Pairs with the combinational ALU: the ALU handles all single-cycle ops; this block takes the same operand buses (busA, tempBus) and executes mult/multu/div/divu over multiple cycles.
- Also services mthi/mtlo writes and supplies hi/lo to the mfhi/mflo datapath.
- The pipeline stalls on busy and may cancel an operation with flush.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_sign_fix.sv | 20 ++
 rtl/mdu_hilo.sv | 187 ++++++++++++++++++
 tb/tb_mdu_hilo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states and
// the iteration count.
package mdu_pkg;

  localparam int unsigned MDU_ITERS = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation of one wide and one narrow value.
// Used both for operand magnitudes and for final sign correction of results.
module mdu_sign_fix #(
  parameter int unsigned WideW   = 64,
  parameter int unsigned NarrowW = 32
) (
  input  logic [WideW-1:0]   wide,
  input  logic               neg_wide,
  input  logic [NarrowW-1:0] narrow,
  input  logic               neg_narrow,
  output logic [WideW-1:0]   wide_res,
  output logic [NarrowW-1:0] narrow_res
);

  always_comb begin
    wide_res   = neg_wide ? (~wide + WideW'(1)) : wide;
    narrow_res = neg_narrow ? (~narrow + NarrowW'(1)) : narrow;
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply/divide unit owning HI/LO. One step per cycle in CALC,
// sign correction and HI/LO write in FIX; mthi/mtlo complete in a single edge.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] tempBus,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(MDU_ITERS);
  localparam logic [CntW-1:0] LastCnt = CntW'(MDU_ITERS - 1);

  mdu_state_e state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Multiply: 64-bit product, multiplier consumed from the low end.
  // Divide: {remainder, quotient}, dividend shifted out of the quotient half.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] fix_wide_in, fix_wide;
  logic [WIDTH-1:0]   fix_rem;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign a_neg     = signed_op & busA[WIDTH-1];
  assign b_neg     = signed_op & tempBus[WIDTH-1];

  mdu_sign_fix #(
    .WideW   (WIDTH),
    .NarrowW (WIDTH)
  ) u_abs (
    .wide       (busA),
    .neg_wide   (a_neg),
    .narrow     (tempBus),
    .neg_narrow (b_neg),
    .wide_res   (abs_a),
    .narrow_res (abs_b)
  );

  assign fix_wide_in = is_div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

  mdu_sign_fix #(
    .WideW   (2 * WIDTH),
    .NarrowW (WIDTH)
  ) u_fix (
    .wide       (fix_wide_in),
    .neg_wide   (sa_q ^ sb_q),
    .narrow     (acc_q[2*WIDTH-1:WIDTH]),
    .neg_narrow (sa_q),
    .wide_res   (fix_wide),
    .narrow_res (fix_rem)
  );

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    // Remainder is always below the divisor, so bit WIDTH of the trial is the borrow.
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    raw_a_d  = raw_a_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d  = StCalc;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, abs_a};
              opnd_d   = abs_b;
              raw_a_d  = busA;
              is_div_d = op[1];
              sa_d     = a_neg;
              sb_d     = b_neg;
              zero_d   = (tempBus == '0);
            end
            MDU_MTHI: hi_d = busA;
            MDU_MTLO: lo_d = busA;
            default: ;
          endcase
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = fix_wide[2*WIDTH-1:WIDTH];
            lo_d = fix_wide[WIDTH-1:0];
          end else if (zero_q) begin
            hi_d = raw_a_q;
            lo_d = '1;
          end else begin
            hi_d = fix_rem;
            lo_d = fix_wide[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      raw_a_q  <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      raw_a_q  <= raw_a_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: directed cases from the plan plus random ops checked
// against an arithmetic reference model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] busA;
  logic [31:0] tempBus;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .busA    (busA),
    .tempBus (tempBus),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns {hi, lo} as defined by the architectural semantics of each op.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      p;
    logic [31:0] q, r;
    case (o)
      3'b000: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      3'b001: return {32'h0, a} * {32'h0, b};
      3'b010: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin : monitor
    logic [63:0] e;
    bit          prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        check(!prev_done, "done_one_cycle", 64'(prev_done), 64'h0);
        check(!busy, "busy_low_at_done", 64'(busy), 64'h0);
        check(sb_q.size() != 0, "unexpected_done", 64'(sb_q.size()), 64'h1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check(hi == e[63:32], "result_hi", 64'(hi), 64'(e[63:32]));
          check(lo == e[31:0], "result_lo", 64'(lo), 64'(e[31:0]));
        end
      end
      prev_done = rst_n && done;
    end
  end

  // Issue a mult/div. Optional: a second start at edge extra_at, flush at edge flush_at,
  // asynchronous reset between edges rst_at and rst_at+1.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int extra_at, input int flush_at, input int rst_at);
    logic [63:0] exp;
    bit          got;
    exp = ref_model(o, a, b);
    if (flush_at < 0 && rst_at < 0) sb_q.push_back(exp);
    start = 1'b1; op = o; busA = a; tempBus = b;
    @(negedge clk);
    start = 1'b0;
    check(busy, "busy_after_accept", 64'(busy), 64'h1);
    got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == extra_at) begin
        start = 1'b1; op = MDU_DIVU; busA = 32'd7; tempBus = 32'd2;
      end
      if (i == flush_at) flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (i == flush_at) begin
        check(!busy, "flush_busy", 64'(busy), 64'h0);
        check(hi == m_hi, "flush_hi", 64'(hi), 64'(m_hi));
        check(lo == m_lo, "flush_lo", 64'(lo), 64'(m_lo));
        repeat (36) @(negedge clk);
        return;
      end
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check(hi == 32'h0, "async_rst_hi", 64'(hi), 64'h0);
        check(lo == 32'h0, "async_rst_lo", 64'(lo), 64'h0);
        check(!busy, "async_rst_busy", 64'(busy), 64'h0);
        check(!done, "async_rst_done", 64'(done), 64'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (i == 32) check(busy && !done, "busy_through_calc", 64'({busy, done}), 64'h2);
      if (done) begin
        check(i == 33, "latency", 64'(i), 64'd33);
        got = 1'b1;
        break;
      end
    end
    check(got, "done_timeout", 64'(got), 64'h1);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(negedge clk);
  endtask

  // Single-edge ops (mthi/mtlo/reserved), optionally with a simultaneous flush.
  task automatic do_move(input logic [2:0] o, input logic [31:0] a, input bit fl);
    start = 1'b1; op = o; busA = a; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    if (!fl && o == MDU_MTHI) m_hi = a;
    if (!fl && o == MDU_MTLO) m_lo = a;
    check(hi == m_hi, "move_hi", 64'(hi), 64'(m_hi));
    check(lo == m_lo, "move_lo", 64'(lo), 64'(m_lo));
    check(!busy && !done, "move_no_busy_done", 64'({busy, done}), 64'h0);
  endtask

  initial begin : stim
    logic [2:0]  o;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b0; busA = '0; tempBus = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check(hi == 32'h0 && lo == 32'h0, "reset_hilo", {hi, lo}, 64'h0);
    check(!busy && !done, "reset_busy_done", 64'({busy, done}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MDU_MULT,  32'hFFFFFFFF, 32'h00000002, -1, -1, -1);
    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1);
    run_op(MDU_DIV,   32'hFFFFFFF9, 32'h00000002, -1, -1, -1);
    run_op(MDU_DIVU,  32'd7,        32'd2,        -1, -1, -1);
    run_op(MDU_DIVU,  32'h12345678, 32'h0,        -1, -1, -1);
    run_op(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, -1, -1, -1);
    run_op(MDU_DIV,   32'h87654321, 32'h0,        -1, -1, -1);
    run_op(MDU_MULT,  32'h00012345, 32'hFFFF8765, 5,  -1, -1);
    run_op(MDU_DIV,   32'h00001000, 32'h00000003, -1, 10, -1);
    do_move(MDU_MTHI, 32'hA5A5A5A5, 1'b0);
    do_move(MDU_MTLO, 32'h5A5A5A5A, 1'b0);
    do_move(3'b110,   32'h11111111, 1'b0);
    do_move(3'b111,   32'h22222222, 1'b0);
    do_move(MDU_MTHI, 32'h33333333, 1'b1);
    run_op(MDU_MULT,  32'h00000123, 32'h00000456, -1, -1, 10);
    run_op(MDU_MULT,  32'h80000000, 32'h80000000, -1, -1, -1);

    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          o = 3'($urandom_range(0, 3));
          run_op(o, a, b, -1, -1, -1);
        end
        6: do_move(MDU_MTHI, a, 1'b0);
        7: do_move(MDU_MTLO, a, 1'b0);
        8: do_move(3'($urandom_range(6, 7)), a, 1'b0);
        default: do_move(3'($urandom_range(4, 5)), a, 1'b1);
      endcase
    end

    repeat (5) @(negedge clk);
    check(sb_q.size() == 0, "scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
